// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_ctrl
//  Desc     : Round sequencer for an iterative AES datapath (AES-128/192/256).
//             It drives the state-register load mux, the register enable, the
//             round counter, the round-key index and the last-round flag. It
//             has a start/busy handshake on the input side and a
//             valid/ready handshake on the output side.
//  Options  : `define AES_RC_DECRYPT_EN adds the 'decrypt' input. When it is
//             latched high, key_idx counts down from Nr to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR_MAX = 14,   // largest round count this instance supports
    parameter int CNT_W  = 4     // width of round / key_idx, 2**CNT_W > NR_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             abort,
`ifdef AES_RC_DECRYPT_EN
    input  logic             decrypt,
`endif
    input  logic             out_ready,
    output logic             busy,
    output logic             sel,
    output logic             reg_en,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] key_idx,
    output logic             last_round,
    output logic             out_valid,
    output logic             err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    // Round counts for each key size, and the instance limit
    localparam logic [CNT_W-1:0] NR_128   = CNT_W'(10);
    localparam logic [CNT_W-1:0] NR_192   = CNT_W'(12);
    localparam logic [CNT_W-1:0] NR_256   = CNT_W'(14);
    localparam logic [CNT_W-1:0] NR_LIMIT = CNT_W'(NR_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] nr_q,    nr_d;
    logic             err_q,   err_d;
`ifdef AES_RC_DECRYPT_EN
    logic             dec_q,   dec_d;
`endif

    // Key-size decode
    logic [CNT_W-1:0] key_nr;
    logic             key_ok;

    // Map key_len to its round count. A key size that needs more rounds than
    // this instance can count is refused the same way as the reserved code.
    always_comb begin
        key_nr = NR_128;
        case (key_len)
            2'b00:   key_nr = NR_128;
            2'b01:   key_nr = NR_192;
            2'b10:   key_nr = NR_256;
            default: key_nr = NR_128;
        endcase
        key_ok = (key_len != 2'b11) && (key_nr <= NR_LIMIT);
    end

    // Next-state logic for the sequencer, round counter, latched Nr and err
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        nr_d    = nr_q;
        err_d   = 1'b0;
`ifdef AES_RC_DECRYPT_EN
        dec_d   = dec_q;
`endif
        if (abort) begin
            // Abort beats start and out_ready. The block is dropped and
            // nothing is presented on the output side.
            state_d = S_IDLE;
            round_d = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (key_ok) begin
                            state_d = S_LOAD;
                            round_d = CNT_ZERO;
                            nr_d    = key_nr;
`ifdef AES_RC_DECRYPT_EN
                            dec_d   = decrypt;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // The initial AddRoundKey happens here, so round 1 comes next.
                    // Only a degenerate Nr of 1 goes straight to the final round.
                    round_d = round_q + CNT_ONE;
                    state_d = (nr_q <= CNT_ONE) ? S_FINAL : S_ROUND;
                end

                S_ROUND: begin
                    // Saturating compare, so the counter cannot pass Nr even if
                    // Nr changed under it.
                    if (round_q >= (nr_q - CNT_ONE)) begin
                        state_d = S_FINAL;
                        round_d = nr_q;
                    end else begin
                        round_d = round_q + CNT_ONE;
                    end
                end

                S_FINAL: begin
                    state_d = S_HOLD;
                end

                S_HOLD: begin
                    // Round stays at Nr until the consumer takes the result.
                    // A start that comes with out_ready chains the next block
                    // without passing through IDLE.
                    if (out_ready) begin
                        if (start && key_ok) begin
                            state_d = S_LOAD;
                            round_d = CNT_ZERO;
                            nr_d    = key_nr;
`ifdef AES_RC_DECRYPT_EN
                            dec_d   = decrypt;
`endif
                        end else begin
                            state_d = S_IDLE;
                            round_d = CNT_ZERO;
                            err_d   = start;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    round_d = CNT_ZERO;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= CNT_ZERO;
            nr_q    <= NR_128;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

`ifdef AES_RC_DECRYPT_EN
    // Direction flag, latched together with Nr on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`endif

    // Datapath controls, decoded from the registered state only
    always_comb begin
        busy       = (state_q == S_LOAD) || (state_q == S_ROUND) ||
                     (state_q == S_FINAL);
        reg_en     = busy;
        sel        = (state_q != S_LOAD);
        last_round = (state_q == S_FINAL);
        out_valid  = (state_q == S_HOLD);
        round      = round_q;
        err        = err_q;
`ifdef AES_RC_DECRYPT_EN
        // Decryption walks the key schedule from the top down
        key_idx    = dec_q ? (nr_q - round_q) : round_q;
`else
        key_idx    = round_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_round_ctrl
//  Desc     : Self-checking bench for aes_round_ctrl. A vector table covers
//             an AES-128 block, followed by hand-written multi-cycle sequences.
//             Build with AES_RC_DECRYPT_EN to include the decrypt key_idx checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       key_len;
    logic             abort;
    logic             decrypt;
    logic             out_ready;
    logic             busy;
    logic             sel;
    logic             reg_en;
    logic [CNT_W-1:0] round;
    logic [CNT_W-1:0] key_idx;
    logic             last_round;
    logic             out_valid;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    aes_round_ctrl #(.NR_MAX(14), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_len    (key_len),
        .abort      (abort),
`ifdef AES_RC_DECRYPT_EN
        .decrypt    (decrypt),
`endif
        .out_ready  (out_ready),
        .busy       (busy),
        .sel        (sel),
        .reg_en     (reg_en),
        .round      (round),
        .key_idx    (key_idx),
        .last_round (last_round),
        .out_valid  (out_valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             sel;
        logic             reg_en;
        logic [CNT_W-1:0] round;
        logic [CNT_W-1:0] key_idx;
        logic             last_round;
        logic             out_valid;
        logic             err;
    } outs_t;

    typedef struct {
        logic       start;
        logic [1:0] key_len;
        logic       abort;
        logic       out_ready;
        outs_t      exp;
    } vec_t;

    // Expected output bundle, with key_idx equal to round
    function automatic outs_t mk(input logic b, input logic s, input logic e,
                                 input logic [CNT_W-1:0] r, input logic l,
                                 input logic v, input logic er);
        mk = '{b, s, e, r, r, l, v, er};
    endfunction

    function automatic outs_t e_idle(input logic er);
        e_idle = mk(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, er);
    endfunction
    function automatic outs_t e_load();
        e_load = mk(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_round(input logic [CNT_W-1:0] r);
        e_round = mk(1'b1, 1'b1, 1'b1, r, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_final(input logic [CNT_W-1:0] r);
        e_final = mk(1'b1, 1'b1, 1'b1, r, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_hold(input logic [CNT_W-1:0] r);
        e_hold = mk(1'b0, 1'b1, 1'b0, r, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic check(input string nm, input outs_t exp);
        outs_t got;
        got = '{busy, sel, reg_en, round, key_idx, last_round, out_valid, err};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b sel=%0b reg_en=%0b round=%0d key_idx=%0d last=%0b valid=%0b err=%0b ; want busy=%0b sel=%0b reg_en=%0b round=%0d key_idx=%0d last=%0b valid=%0b err=%0b",
                     nm, got.busy, got.sel, got.reg_en, got.round, got.key_idx,
                     got.last_round, got.out_valid, got.err,
                     exp.busy, exp.sel, exp.reg_en, exp.round, exp.key_idx,
                     exp.last_round, exp.out_valid, exp.err);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one block and check every cycle up to and including the first HOLD
    // cycle. On return out_ready=0 and the DUT is in HOLD.
    task automatic run_to_hold(input logic [1:0] kl, input int nr,
                               input logic rdy_at_start, input string tag);
        start     = 1'b1;
        key_len   = kl;
        out_ready = rdy_at_start;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check({tag, " load"}, e_load());
        for (int k = 1; k < nr; k++) begin
            step();
            check({tag, " round"}, e_round(CNT_W'(k)));
        end
        step();
        check({tag, " final"}, e_final(CNT_W'(nr)));
        step();
        check({tag, " hold"}, e_hold(CNT_W'(nr)));
    endtask

    vec_t vecs[15];

    initial begin
        // AES-128 with out_ready held high. The start edge is vector 0 and
        // out_valid is first seen 11 edges later, at vector 11.
        vecs[0] = '{1'b1, 2'b00, 1'b0, 1'b1, e_load()};
        for (int k = 1; k <= 9; k++)
            vecs[k] = '{1'b0, 2'b00, 1'b0, 1'b1, e_round(CNT_W'(k))};
        // start with the reserved key_len while busy must be ignored silently
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 1'b1, e_round(4'd5)};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 1'b1, e_final(4'd10)};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 1'b1, e_hold(4'd10)};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 1'b1, e_idle(1'b0)};
        vecs[13] = '{1'b1, 2'b11, 1'b0, 1'b0, e_idle(1'b1)};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 1'b0, e_idle(1'b0)};

        rst_n = 1'b0; start = 1'b0; key_len = 2'b00; abort = 1'b0;
        decrypt = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", e_idle(1'b0));
        rst_n = 1'b1;
        step();
        check("idle after reset", e_idle(1'b0));

        // ---- Table-driven AES-128 block and the reserved-key error ----
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start; key_len = vecs[i].key_len;
            abort = vecs[i].abort; out_ready = vecs[i].out_ready;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end
        start = 1'b0; out_ready = 1'b0;

        // ---- AES-192: HOLD for 3 cycles, with a start that lacks out_ready ----
        run_to_hold(2'b01, 12, 1'b0, "aes192");
        start = 1'b1; key_len = 2'b00;
        step();
        check("aes192 hold2 start ignored", e_hold(4'd12));
        start = 1'b0;
        step();
        check("aes192 hold3", e_hold(4'd12));
        out_ready = 1'b1;
        step();
        check("aes192 release", e_idle(1'b0));
        out_ready = 1'b0;

        // ---- AES-256: HOLD for 3 cycles, then a back-to-back AES-256 ----
        run_to_hold(2'b10, 14, 1'b0, "aes256");
        step();
        check("aes256 hold2", e_hold(4'd14));
        step();
        check("aes256 hold3", e_hold(4'd14));
        run_to_hold(2'b10, 14, 1'b1, "b2b256");
        // HOLD + out_ready + reserved key: drop to IDLE and pulse err
        start = 1'b1; key_len = 2'b11; out_ready = 1'b1;
        step();
        check("hold bad key", e_idle(1'b1));
        start = 1'b0; out_ready = 1'b0;
        step();
        check("err one cycle", e_idle(1'b0));

        // ---- Abort at round 7 ----
        start = 1'b1; key_len = 2'b00; out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("abort pre round7", e_round(4'd7));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort to idle", e_idle(1'b0));
        begin
            int seen_valid;
            seen_valid = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (out_valid) seen_valid++;
            end
            chk_int("abort no out_valid", seen_valid, 0);
        end
        check("abort stays idle", e_idle(1'b0));

        // ---- Asynchronous reset in the middle of ROUND ----
        start = 1'b1; key_len = 2'b00;
        step();
        start = 1'b0;
        repeat (5) step();
        check("pre reset round5", e_round(4'd5));
        #1 rst_n = 1'b0;
        #1;
        check("async reset mid-round", e_idle(1'b0));
        #1 rst_n = 1'b1;
        step();
        check("idle after mid reset", e_idle(1'b0));
        out_ready = 1'b0;

`ifdef AES_RC_DECRYPT_EN
        // ---- Decrypt: key_idx runs 10..0 against round 0..10 ----
        decrypt = 1'b1; start = 1'b1; key_len = 2'b00; out_ready = 1'b1;
        step();
        start = 1'b0; decrypt = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) step();
            chk_int($sformatf("dec round%0d", k), int'(round), k);
            chk_int($sformatf("dec key_idx%0d", k), int'(key_idx), 10 - k);
        end
        chk_int("dec last_round", int'(last_round), 1);
        step();
        step();
        // ---- Encrypt again: key_idx follows round ----
        start = 1'b1; key_len = 2'b00;
        step();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) step();
            chk_int($sformatf("enc key_idx%0d", k), int'(key_idx), k);
        end
        step();
        step();
        check("enc back to idle", e_idle(1'b0));
        out_ready = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
